// File: rtl/aes_sub_bytes_seq_pkg.sv
// Shared definitions for the iterative AES SubBytes stage: block/byte widths,
// FSM state encoding and byte-slice helpers (byte 0 is the most significant
// byte of the 128-bit state, matching FIPS-197 input order).
package aes_sub_bytes_seq_pkg;

    localparam int AES_BLOCK_W = 128;
    localparam int AES_BYTE_W  = 8;
    localparam int AES_NBYTES  = AES_BLOCK_W / AES_BYTE_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SUB  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Byte i of a block lives at [127-8i -: 8].
    function automatic logic [AES_BYTE_W-1:0] get_byte(
        input logic [AES_BLOCK_W-1:0] blk,
        input int                     idx
    );
        return blk[(AES_BLOCK_W - 1) - (AES_BYTE_W * idx) -: AES_BYTE_W];
    endfunction

    // Returns blk with byte i replaced by val.
    function automatic logic [AES_BLOCK_W-1:0] put_byte(
        input logic [AES_BLOCK_W-1:0] blk,
        input int                     idx,
        input logic [AES_BYTE_W-1:0]  val
    );
        logic [AES_BLOCK_W-1:0] res;
        res = blk;
        res[(AES_BLOCK_W - 1) - (AES_BYTE_W * idx) -: AES_BYTE_W] = val;
        return res;
    endfunction

endpackage

// File: rtl/aes_sub_bytes_seq_sbox.sv
// Combinational AES forward S-box: one byte in, substituted byte out.
module aes_sub_bytes_seq_sbox
    import aes_sub_bytes_seq_pkg::*;
(
    input  logic [AES_BYTE_W-1:0] addr_i,
    output logic [AES_BYTE_W-1:0] result_o
);

    localparam logic [7:0] SBOX_ROM [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign result_o = SBOX_ROM[addr_i];

endmodule

// File: rtl/aes_sub_bytes_seq.sv
// Iterative AES SubBytes: a 128-bit state is captured, BPC bytes per cycle
// are pushed through BPC S-boxes and written back in place, and the finished
// state is held on the output until downstream takes it. In DONE, in_ready
// follows out_ready so a new block can be taken in the same cycle the result
// leaves (no input bubble).
module aes_sub_bytes_seq
    import aes_sub_bytes_seq_pkg::*;
#(
    parameter int BPC = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [AES_BLOCK_W-1:0] in_state,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [AES_BLOCK_W-1:0] out_state,
    output logic                   busy
);

    localparam int NSTEP = AES_NBYTES / BPC;
    localparam int CNT_W = (NSTEP > 1) ? $clog2(NSTEP) : 1;
    localparam bit BPC_OK = (BPC == 1) || (BPC == 2) || (BPC == 4) ||
                            (BPC == 8) || (BPC == 16);

    generate
        if (!BPC_OK) begin : g_bpc_illegal
            $error("aes_sub_bytes_seq: BPC must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    state_e                 state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [AES_BLOCK_W-1:0] work_q;
    logic [AES_BLOCK_W-1:0] work_d;
    logic [AES_BLOCK_W-1:0] out_state_q;
    logic                   out_valid_q;
    logic                   busy_q;

    logic [AES_BYTE_W-1:0]  sbox_in_s  [BPC];
    logic [AES_BYTE_W-1:0]  sbox_out_s [BPC];

    // Select the current byte group of the work register as S-box inputs.
    always_comb begin
        for (int j = 0; j < BPC; j++) begin
            sbox_in_s[j] = get_byte(work_q, (int'(cnt_q) * BPC) + j);
        end
    end

    generate
        for (genvar g = 0; g < BPC; g++) begin : g_sbox
            aes_sub_bytes_seq_sbox u_sbox (
                .addr_i   (sbox_in_s[g]),
                .result_o (sbox_out_s[g])
            );
        end
    endgenerate

    // Work register with the current byte group replaced by its substitutes.
    always_comb begin
        work_d = work_q;
        for (int j = 0; j < BPC; j++) begin
            work_d = put_byte(work_d, (int'(cnt_q) * BPC) + j, sbox_out_s[j]);
        end
    end

    // Input ready: always in IDLE, follows out_ready in DONE, never in SUB.
    always_comb begin
        case (state_q)
            ST_IDLE: in_ready = 1'b1;
            ST_DONE: in_ready = out_ready;
            ST_SUB:  in_ready = 1'b0;
            default: in_ready = 1'b0;
        endcase
    end

    // Control FSM, step counter, work register and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= {CNT_W{1'b0}};
            work_q      <= {AES_BLOCK_W{1'b0}};
            out_state_q <= {AES_BLOCK_W{1'b0}};
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        work_q  <= in_state;
                        cnt_q   <= {CNT_W{1'b0}};
                        busy_q  <= 1'b1;
                        state_q <= ST_SUB;
                    end
                end
                ST_SUB: begin
                    work_q <= work_d;
                    if (cnt_q == CNT_W'(NSTEP - 1)) begin
                        out_state_q <= work_d;
                        out_valid_q <= 1'b1;
                        busy_q      <= 1'b0;
                        cnt_q       <= {CNT_W{1'b0}};
                        state_q     <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        if (in_valid) begin
                            // Result leaves and the next block enters together.
                            work_q  <= in_state;
                            cnt_q   <= {CNT_W{1'b0}};
                            busy_q  <= 1'b1;
                            state_q <= ST_SUB;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    cnt_q       <= {CNT_W{1'b0}};
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign out_state = out_state_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_aes_sub_bytes_seq.sv
// Directed bench for aes_sub_bytes_seq: one instance per legal BPC
// (index g has BPC = 1 << g), driven through shared clock/reset/data.
module tb_aes_sub_bytes_seq;

    logic         clk = 1'b0;
    logic         reset;
    logic [127:0] in_state;
    logic [4:0]   in_valid_v;
    logic [4:0]   in_ready_v;
    logic [4:0]   out_valid_v;
    logic [4:0]   out_ready_v;
    logic [4:0]   busy_v;
    logic [127:0] out_state_v [5];

    int n_cmp  = 0;
    int n_fail = 0;

    localparam logic [127:0] VEC_R1_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam logic [127:0] VEC_R1_OUT = 128'hd42711aee0bf98f1b8b45de51e415230;
    localparam logic [127:0] VEC_SEQ_IN = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] VEC_SEQ_OUT= 128'h637c777bf26b6fc53001672bfed7ab76;

    always #5 clk = ~clk;

    generate
        for (genvar g = 0; g < 5; g++) begin : g_dut
            aes_sub_bytes_seq #(.BPC(1 << g)) u_dut (
                .clk       (clk),
                .reset     (reset),
                .in_valid  (in_valid_v[g]),
                .in_ready  (in_ready_v[g]),
                .in_state  (in_state),
                .out_valid (out_valid_v[g]),
                .out_ready (out_ready_v[g]),
                .out_state (out_state_v[g]),
                .busy      (busy_v[g])
            );
        end
    endgenerate

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present din at a negedge, let the next posedge accept it, then scramble in_state.
    task automatic accept(input int d, input logic [127:0] din, input string tag);
        @(negedge clk);
        in_state      = din;
        in_valid_v[d] = 1'b1;
        check({tag, "/in_ready_idle"}, 128'(in_ready_v[d]), 128'd1);
        @(negedge clk);
        in_valid_v[d] = 1'b0;
        in_state      = 128'hdeadbeefcafef00d0123456789abcdef;
    endtask

    // Called at the negedge after the accept edge; returns edges until out_valid.
    task automatic wait_out(input int d, output int lat, output int busy_cnt);
        busy_cnt = busy_v[d] ? 1 : 0;
        lat      = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (busy_v[d]) busy_cnt++;
            if (out_valid_v[d]) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic run_block(input int d, input logic [127:0] din, input logic [127:0] exp,
                             input int exp_lat, input bit hold, input string tag);
        int lat;
        int bcnt;
        out_ready_v[d] = !hold;
        accept(d, din, tag);
        wait_out(d, lat, bcnt);
        check({tag, "/latency"}, 128'(lat), 128'(exp_lat));
        check({tag, "/busy_cycles"}, 128'(bcnt), 128'(exp_lat));
        check({tag, "/out_state"}, out_state_v[d], exp);
        if (hold) begin
            for (int k = 0; k < 10; k++) begin
                @(negedge clk);
                check({tag, "/hold_state"}, out_state_v[d], exp);
                check({tag, "/hold_valid"}, 128'(out_valid_v[d]), 128'd1);
                check({tag, "/hold_in_ready"}, 128'(in_ready_v[d]), 128'd0);
            end
            out_ready_v[d] = 1'b1;
            #1;
            check({tag, "/in_ready_follows_out_ready"}, 128'(in_ready_v[d]), 128'd1);
        end
        @(negedge clk);
        check({tag, "/post_valid"}, 128'(out_valid_v[d]), 128'd0);
        check({tag, "/post_in_ready"}, 128'(in_ready_v[d]), 128'd1);
    endtask

    initial begin
        int lat;
        int bcnt;
        reset       = 1'b1;
        in_state    = 128'h0;
        in_valid_v  = 5'b00000;
        out_ready_v = 5'b11111;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Reset state of every instance.
        for (int d = 0; d < 5; d++) begin
            check("reset/out_valid", 128'(out_valid_v[d]), 128'd0);
            check("reset/busy", 128'(busy_v[d]), 128'd0);
            check("reset/in_ready", 128'(in_ready_v[d]), 128'd1);
            check("reset/out_state", out_state_v[d], 128'h0);
        end

        // FIPS-197 round 1 SubBytes, BPC=1.
        run_block(0, VEC_R1_IN, VEC_R1_OUT, 16, 1'b0, "r1_bpc1");

        // Boundary bytes, BPC=4.
        run_block(2, {16{8'h00}}, {16{8'h63}}, 4, 1'b0, "zeros_bpc4");
        run_block(2, {16{8'hff}}, {16{8'h16}}, 4, 1'b0, "ones_bpc4");

        // Backpressure for 10 cycles, BPC=1.
        run_block(0, VEC_SEQ_IN, VEC_SEQ_OUT, 16, 1'b1, "bp_bpc1");

        // Back-to-back blocks with zero input bubble, BPC=1.
        out_ready_v[0] = 1'b1;
        @(negedge clk);
        in_state      = VEC_SEQ_IN;
        in_valid_v[0] = 1'b1;
        @(negedge clk);
        in_state = VEC_R1_IN;
        wait_out(0, lat, bcnt);
        check("b2b/first_latency", 128'(lat), 128'd16);
        check("b2b/first_state", out_state_v[0], VEC_SEQ_OUT);
        check("b2b/in_ready_done", 128'(in_ready_v[0]), 128'd1);
        @(negedge clk);
        in_valid_v[0] = 1'b0;
        in_state      = 128'h0;
        check("b2b/valid_dropped", 128'(out_valid_v[0]), 128'd0);
        check("b2b/busy_direct", 128'(busy_v[0]), 128'd1);
        wait_out(0, lat, bcnt);
        check("b2b/second_latency", 128'(lat), 128'd16);
        check("b2b/second_state", out_state_v[0], VEC_R1_OUT);
        @(negedge clk);
        check("b2b/idle_valid", 128'(out_valid_v[0]), 128'd0);

        // Reset after 7 substitution steps, BPC=1.
        accept(0, VEC_SEQ_IN, "rst_mid");
        repeat (7) @(negedge clk);
        check("rst_mid/busy_before", 128'(busy_v[0]), 128'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst_mid/out_valid", 128'(out_valid_v[0]), 128'd0);
        check("rst_mid/busy", 128'(busy_v[0]), 128'd0);
        check("rst_mid/in_ready", 128'(in_ready_v[0]), 128'd1);
        check("rst_mid/out_state", out_state_v[0], 128'h0);
        run_block(0, VEC_R1_IN, VEC_R1_OUT, 16, 1'b0, "after_rst");

        // Parameter sweep on the round 1 vector.
        run_block(1, VEC_R1_IN, VEC_R1_OUT, 8, 1'b0, "r1_bpc2");
        run_block(3, VEC_R1_IN, VEC_R1_OUT, 2, 1'b0, "r1_bpc8");
        run_block(4, VEC_R1_IN, VEC_R1_OUT, 1, 1'b0, "r1_bpc16");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
